// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing (default geometry) in the pixel clock
// domain. DrawX/DrawY come straight from the counters. blank, hsync, vsync and
// frame_start pass through short delay lines so they line up with the
// downstream sprite renderer's ROM read and registered RGB stages.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned BLANK_DELAY = 1,
  parameter int unsigned SYNC_DELAY  = 2
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Terminal counts at counter width; decode bounds one bit wider so that an
  // end bound equal to 1024 cannot alias to zero.
  localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  // Geometry must fit the 10-bit counters; delay lines need at least one stage.
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_geometry
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit counter range");
  end
  if (BLANK_DELAY < 1 || SYNC_DELAY < 1) begin : g_bad_delay
    $error("vga_timing_gen: BLANK_DELAY and SYNC_DELAY must be >= 1");
  end

  logic [9:0]             hc_q, hc_d;
  logic [9:0]             vc_q, vc_d;
  logic [7:0]             fc_q, fc_d;
  logic                   act, hs_n, vs_n, fs;
  logic [BLANK_DELAY-1:0] blank_q, blank_d;
  logic [SYNC_DELAY-1:0]  hs_q, hs_d;
  logic [SYNC_DELAY-1:0]  vs_q, vs_d;
  logic [SYNC_DELAY-1:0]  fs_q, fs_d;

  // Next-state for the raster counters and the completed-frame counter.
  always_comb begin
    hc_d = hc_q + 10'd1;
    vc_d = vc_q;
    fc_d = fc_q;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      if (vc_q == V_LAST) begin
        vc_d = '0;
        fc_d = fc_q + 8'd1;
      end else begin
        vc_d = vc_q + 10'd1;
      end
    end
  end

  // Combinational raster decode; vs_n depends on vc only, so it moves only at hc wrap.
  always_comb begin
    act  = ({1'b0, hc_q} < H_ACT) && ({1'b0, vc_q} < V_ACT);
    hs_n = !(({1'b0, hc_q} >= HS_BEG) && ({1'b0, hc_q} < HS_END));
    vs_n = !(({1'b0, vc_q} >= VS_BEG) && ({1'b0, vc_q} < VS_END));
    fs   = (hc_q == '0) && (vc_q == '0);
  end

  // Delay-line shift: new decode enters at bit 0, output taken from the MSB.
  // The single-stage case is split out so no zero-width slice is elaborated.
  if (BLANK_DELAY == 1) begin : g_blank_1
    always_comb blank_d = act;
  end else begin : g_blank_n
    always_comb blank_d = {blank_q[BLANK_DELAY-2:0], act};
  end

  if (SYNC_DELAY == 1) begin : g_sync_1
    always_comb begin
      hs_d = hs_n;
      vs_d = vs_n;
      fs_d = fs;
    end
  end else begin : g_sync_n
    always_comb begin
      hs_d = {hs_q[SYNC_DELAY-2:0], hs_n};
      vs_d = {vs_q[SYNC_DELAY-2:0], vs_n};
      fs_d = {fs_q[SYNC_DELAY-2:0], fs};
    end
  end

  // Counter and delay-line registers; reset clears every stage to idle levels.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_q    <= '0;
      vc_q    <= '0;
      fc_q    <= '0;
      blank_q <= '0;
      hs_q    <= '1;
      vs_q    <= '1;
      fs_q    <= '0;
    end else begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      fc_q    <= fc_d;
      blank_q <= blank_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= fs_d;
    end
  end

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign frame_count = fc_q;
  assign blank       = blank_q[BLANK_DELAY-1];
  assign hsync       = hs_q[SYNC_DELAY-1];
  assign vsync       = vs_q[SYNC_DELAY-1];
  assign frame_start = fs_q[SYNC_DELAY-1];

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen. Three instances share
// one clock: full 640x480 geometry, full geometry with longer delay lines, and
// a tiny geometry (15x8 clocks per frame) so frame counting and wrap fit in a
// short run. Expected values come from hand geometry tables, not the DUT.
module tb_vga_timing_gen;

  typedef struct {
    int ha; int hfp; int hs; int ht;
    int va; int vfp; int vs; int vt;
  } geom_t;

  geom_t g_full  = '{640, 16, 96, 800, 480, 10, 2, 525};
  geom_t g_small = '{8, 2, 3, 15, 4, 1, 2, 8};

  logic vga_clk = 1'b0;
  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;

  always #20 vga_clk = ~vga_clk;

  logic [9:0] dx_f, dy_f, dx_d, dy_d, dx_s, dy_s;
  logic       bl_f, hs_f, vs_f, fs_f;
  logic       bl_d, hs_d, vs_d, fs_d;
  logic       bl_s, hs_s, vs_s, fs_s;
  logic [7:0] fc_f, fc_d, fc_s;

  vga_timing_gen u_full (
    .vga_clk(vga_clk), .reset_n(rst_a_n), .DrawX(dx_f), .DrawY(dy_f),
    .blank(bl_f), .hsync(hs_f), .vsync(vs_f), .frame_start(fs_f), .frame_count(fc_f)
  );

  vga_timing_gen #(.BLANK_DELAY(3), .SYNC_DELAY(4)) u_dly (
    .vga_clk(vga_clk), .reset_n(rst_a_n), .DrawX(dx_d), .DrawY(dy_d),
    .blank(bl_d), .hsync(hs_d), .vsync(vs_d), .frame_start(fs_d), .frame_count(fc_d)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_small (
    .vga_clk(vga_clk), .reset_n(rst_b_n), .DrawX(dx_s), .DrawY(dy_s),
    .blank(bl_s), .hsync(hs_s), .vsync(vs_s), .frame_start(fs_s), .frame_count(fc_s)
  );

  int vec_cnt = 0;
  int err_cnt = 0;
  int cur_k   = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    vec_cnt++;
    if (got != exp) begin
      err_cnt++;
      if (err_cnt <= 50)
        $display("FAIL %s k=%0d: got %0d, expected %0d", tag, cur_k, got, exp);
    end
  endtask

  // Expected waveforms at clock k after reset release (k = edges seen).
  function automatic int e_hc(geom_t g, int k);
    return k % g.ht;
  endfunction
  function automatic int e_vc(geom_t g, int k);
    return (k / g.ht) % g.vt;
  endfunction
  function automatic int e_blank(geom_t g, int k, int d);
    if (k < d) return 0;
    return (e_hc(g, k - d) < g.ha && e_vc(g, k - d) < g.va) ? 1 : 0;
  endfunction
  function automatic int e_hsync(geom_t g, int k, int d);
    int h;
    if (k < d) return 1;
    h = e_hc(g, k - d);
    return (h >= g.ha + g.hfp && h < g.ha + g.hfp + g.hs) ? 0 : 1;
  endfunction
  function automatic int e_vsync(geom_t g, int k, int d);
    int v;
    if (k < d) return 1;
    v = e_vc(g, k - d);
    return (v >= g.va + g.vfp && v < g.va + g.vfp + g.vs) ? 0 : 1;
  endfunction
  function automatic int e_fs(geom_t g, int k, int d);
    if (k < d) return 0;
    return (((k - d) % (g.ht * g.vt)) == 0) ? 1 : 0;
  endfunction
  function automatic int e_fc(geom_t g, int k);
    return (k / (g.ht * g.vt)) % 256;
  endfunction

  task automatic check_reset_a(input string tag);
    check_val({tag, "_dx"},  32'(dx_f), 0);
    check_val({tag, "_dy"},  32'(dy_f), 0);
    check_val({tag, "_bl"},  32'(bl_f), 0);
    check_val({tag, "_hs"},  32'(hs_f), 1);
    check_val({tag, "_vs"},  32'(vs_f), 1);
    check_val({tag, "_fs"},  32'(fs_f), 0);
    check_val({tag, "_fc"},  32'(fc_f), 0);
    check_val({tag, "_dbl"}, 32'(bl_d), 0);
    check_val({tag, "_dhs"}, 32'(hs_d), 1);
    check_val({tag, "_dvs"}, 32'(vs_d), 1);
    check_val({tag, "_dfs"}, 32'(fs_d), 0);
    check_val({tag, "_ddx"}, 32'(dx_d), 0);
  endtask

  task automatic check_reset_b(input string tag);
    check_val({tag, "_dx"}, 32'(dx_s), 0);
    check_val({tag, "_dy"}, 32'(dy_s), 0);
    check_val({tag, "_bl"}, 32'(bl_s), 0);
    check_val({tag, "_hs"}, 32'(hs_s), 1);
    check_val({tag, "_vs"}, 32'(vs_s), 1);
    check_val({tag, "_fs"}, 32'(fs_s), 0);
    check_val({tag, "_fc"}, 32'(fc_s), 0);
  endtask

  // Full-geometry instances; entered on the negedge where reset was released.
  task automatic run_full(input int n);
    for (int k = 0; k < n; k++) begin
      if (k != 0) begin
        @(posedge vga_clk);
        @(negedge vga_clk);
      end
      cur_k = k;
      check_val("f_drawx", 32'(dx_f), e_hc(g_full, k));
      check_val("f_drawy", 32'(dy_f), e_vc(g_full, k));
      check_val("f_blank", 32'(bl_f), e_blank(g_full, k, 1));
      check_val("f_hsync", 32'(hs_f), e_hsync(g_full, k, 2));
      check_val("f_vsync", 32'(vs_f), e_vsync(g_full, k, 2));
      check_val("f_fstart", 32'(fs_f), e_fs(g_full, k, 2));
      check_val("f_fcount", 32'(fc_f), e_fc(g_full, k));
      check_val("d_drawx", 32'(dx_d), e_hc(g_full, k));
      check_val("d_drawy", 32'(dy_d), e_vc(g_full, k));
      check_val("d_blank", 32'(bl_d), e_blank(g_full, k, 3));
      check_val("d_hsync", 32'(hs_d), e_hsync(g_full, k, 4));
      check_val("d_vsync", 32'(vs_d), e_vsync(g_full, k, 4));
      check_val("d_fstart", 32'(fs_d), e_fs(g_full, k, 4));
    end
  endtask

  // Small-geometry instance, plus per-frame totals and frame_start spacing.
  task automatic run_small(input int n);
    int bcnt = 0;
    int vcnt = 0;
    int fs_first = -1;
    int fs_second = -1;
    int wraps = 0;
    int prev_fc = 0;
    for (int k = 0; k < n; k++) begin
      if (k != 0) begin
        @(posedge vga_clk);
        @(negedge vga_clk);
      end
      cur_k = k;
      check_val("s_drawx", 32'(dx_s), e_hc(g_small, k));
      check_val("s_drawy", 32'(dy_s), e_vc(g_small, k));
      check_val("s_blank", 32'(bl_s), e_blank(g_small, k, 1));
      check_val("s_hsync", 32'(hs_s), e_hsync(g_small, k, 2));
      check_val("s_vsync", 32'(vs_s), e_vsync(g_small, k, 2));
      check_val("s_fstart", 32'(fs_s), e_fs(g_small, k, 2));
      check_val("s_fcount", 32'(fc_s), e_fc(g_small, k));
      if (k >= 1 && k <= 120 && bl_s) bcnt++;
      if (k < 120 && !vs_s) vcnt++;
      if (fs_s) begin
        if (fs_first < 0) fs_first = k;
        else if (fs_second < 0) fs_second = k;
      end
      if (prev_fc == 255 && fc_s == 8'd0) wraps++;
      prev_fc = 32'(fc_s);
    end
    cur_k = n - 1;
    check_val("s_blank_per_frame", bcnt, 32);
    check_val("s_vsync_low_per_frame", vcnt, 30);
    check_val("s_first_fstart", fs_first, 2);
    if (n >= 240) check_val("s_fstart_period", fs_second - fs_first, 120);
    if (n > 30720) check_val("s_fcount_wraps", wraps, 1);
  endtask

  initial begin
    // Power-on reset held across several edges.
    repeat (3) @(negedge vga_clk);
    check_reset_a("por_a");
    check_reset_b("por_b");

    // Line 0, line 1 and part of line 2, up to hc=700 on vc=2.
    rst_a_n = 1'b1;
    run_full(2301);
    check_val("pre_rst_drawx", 32'(dx_f), 700);
    check_val("pre_rst_hsync", 32'(hs_f), 0);

    // Asynchronous reset between clock edges, mid-line.
    #5 rst_a_n = 1'b0;
    #1 check_reset_a("async_a");
    repeat (2) @(negedge vga_clk);
    check_reset_a("held_a");
    rst_a_n = 1'b1;
    run_full(900);

    // Small geometry: 257+ frames to exercise frame_count wrap, stop mid-vsync.
    rst_b_n = 1'b1;
    run_small(30923);
    check_val("pre_rst_s_vsync", 32'(vs_s), 0);
    check_val("pre_rst_s_fcount", 32'(fc_s), 1);
    #5 rst_b_n = 1'b0;
    #1 check_reset_b("async_b");
    @(negedge vga_clk);
    rst_b_n = 1'b1;
    run_small(250);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d", vec_cnt, err_cnt);
    $fatal(1, "time limit");
  end

endmodule
